// File: rtl/trig_pkg.sv
//============================================================================
// Module      : trig_pkg
// Description : Shared constants and helpers for the raycaster trig lookup.
//               Holds the binary-angle geometry (10-bit angle, quadrant
//               boundaries), default output format (Q4.16 in a 20-bit word)
//               and the real-to-fixed conversion used to build the tables.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package trig_pkg;

  // Binary angle: 1024 steps per full turn
  localparam int ANGLE_BITS = 10;
  localparam int N_ANGLES   = 1 << ANGLE_BITS;
  localparam int Q90        = 256;
  localparam int Q180       = 512;
  localparam int Q270       = 768;

  // Default output format: signed Q4.16 in a 20-bit word
  localparam int WIDTH_TRIG_DEF = 20;
  localparam int FRAC_BITS_DEF  = 16;
  localparam int ONE            = 1 << FRAC_BITS_DEF;

  localparam real PI = 3.14159265358979323846;

  // Binary angle to radians; the angle wraps modulo one turn.
  function automatic real angle_to_rad(input int angle);
    return real'(angle % N_ANGLES) * 2.0 * PI / real'(N_ANGLES);
  endfunction

  // Scale by 2^frac_bits, round to nearest with ties away from zero, and
  // clamp to the symmetric range +/-(2^(width-1)-1). The most negative
  // two's complement code is deliberately never produced.
  function automatic longint real_to_fix(input real value,
                                         input int  frac_bits,
                                         input int  width);
    real    scaled;
    real    maxv;
    real    rnd;
    longint maxv_i;
    maxv_i = (64'sd1 <<< (width - 1)) - 64'sd1;
    maxv   = real'(maxv_i);
    scaled = value * real'(64'sd1 <<< frac_bits);
    if (scaled >= maxv) begin
      rnd = maxv;
    end else if (scaled <= -maxv) begin
      rnd = -maxv;
    end else if (scaled >= 0.0) begin
      rnd = $floor(scaled + 0.5);
    end else begin
      rnd = -$floor(-scaled + 0.5);
    end
    return longint'(rnd);
  endfunction

endpackage : trig_pkg

`default_nettype wire

// File: rtl/trig_table_rom.sv
//============================================================================
// Module      : trig_table_rom
// Description : Elaboration-time trig tables with a purely combinational
//               read. sin comes from a 257-entry quarter-wave table with
//               quadrant folding; cos reuses the same table at angle+90deg.
//               tan and -cot (reported as "atan") are full 1024-entry
//               tables, with the poles pinned to +MAXV.
//
// Ports       : angle_i  - binary angle, 1024 steps per turn
//               sin_o    - sin(angle),  signed fixed point
//               cos_o    - cos(angle),  signed fixed point
//               tan_o    - tan(angle),  signed fixed point, saturated
//               atan_o   - -1/tan(angle), signed fixed point, saturated
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module trig_table_rom
  import trig_pkg::*;
#(
  parameter int WIDTH_TRIG = WIDTH_TRIG_DEF,
  parameter int FRAC_BITS  = FRAC_BITS_DEF
) (
  input  logic        [ANGLE_BITS-1:0] angle_i,
  output logic signed [WIDTH_TRIG-1:0] sin_o,
  output logic signed [WIDTH_TRIG-1:0] cos_o,
  output logic signed [WIDTH_TRIG-1:0] tan_o,
  output logic signed [WIDTH_TRIG-1:0] atan_o
);

  localparam longint                      MAXV   = (64'sd1 <<< (WIDTH_TRIG - 1)) - 64'sd1;
  localparam logic signed [WIDTH_TRIG-1:0] MAXV_W = WIDTH_TRIG'(MAXV);

  // Quarter-wave index width: 0..Q90 inclusive needs one bit more than
  // the in-quadrant offset.
  localparam int QIDX_BITS = ANGLE_BITS - 1;

  logic signed [WIDTH_TRIG-1:0] quarter_tab [0:Q90];
  logic signed [WIDTH_TRIG-1:0] tan_tab     [0:N_ANGLES-1];
  logic signed [WIDTH_TRIG-1:0] ncot_tab    [0:N_ANGLES-1];

  // --------------------------------------------------------------------
  // Table construction. Every entry is a constant expression of the index,
  // so these are fixed for the lifetime of the simulation.
  // --------------------------------------------------------------------
  for (genvar k = 0; k <= Q90; k++) begin : g_quarter
    assign quarter_tab[k] =
      WIDTH_TRIG'(real_to_fix($sin(angle_to_rad(k)), FRAC_BITS, WIDTH_TRIG));
  end

  for (genvar a = 0; a < N_ANGLES; a++) begin : g_full
    // tan blows up at 90 and 270 degrees; the float result there is huge
    // but its sign is arbitrary, so the pole is pinned to +MAXV.
    if (a == Q90 || a == Q270) begin : g_tan_pole
      assign tan_tab[a] = MAXV_W;
    end else begin : g_tan_val
      assign tan_tab[a] =
        WIDTH_TRIG'(real_to_fix($tan(angle_to_rad(a)), FRAC_BITS, WIDTH_TRIG));
    end

    // -cot blows up where tan is zero (0 and 180 degrees).
    if (a == 0 || a == Q180) begin : g_ncot_pole
      assign ncot_tab[a] = MAXV_W;
    end else begin : g_ncot_val
      assign ncot_tab[a] =
        WIDTH_TRIG'(real_to_fix(-1.0 / $tan(angle_to_rad(a)), FRAC_BITS, WIDTH_TRIG));
    end
  end

  // --------------------------------------------------------------------
  // Quadrant folding.
  //   quadrant bit 0 set  -> walk the quarter wave backwards (Q90 - offset)
  //   quadrant bit 1 set  -> negate the result
  // At offset 0 of an odd quadrant the index lands on Q90 itself, which is
  // why the quarter table carries 257 entries.
  // --------------------------------------------------------------------
  function automatic logic [QIDX_BITS-1:0] fold_index(input logic [ANGLE_BITS-1:0] a);
    logic [QIDX_BITS-1:0] offset;
    offset = {1'b0, a[ANGLE_BITS-3:0]};
    if (a[ANGLE_BITS-2]) begin
      return QIDX_BITS'(Q90) - offset;
    end else begin
      return offset;
    end
  endfunction

  logic        [ANGLE_BITS-1:0] cos_angle;
  logic        [QIDX_BITS-1:0]  sin_idx;
  logic        [QIDX_BITS-1:0]  cos_idx;
  logic signed [WIDTH_TRIG-1:0] sin_mag;
  logic signed [WIDTH_TRIG-1:0] cos_mag;

  // cos(a) = sin(a + 90deg); the add wraps naturally modulo one turn.
  assign cos_angle = angle_i + ANGLE_BITS'(Q90);

  assign sin_idx = fold_index(angle_i);
  assign cos_idx = fold_index(cos_angle);
  assign sin_mag = quarter_tab[sin_idx];
  assign cos_mag = quarter_tab[cos_idx];

  // Magnitudes never exceed MAXV, so negation cannot overflow.
  assign sin_o  = angle_i[ANGLE_BITS-1]   ? -sin_mag : sin_mag;
  assign cos_o  = cos_angle[ANGLE_BITS-1] ? -cos_mag : cos_mag;
  assign tan_o  = tan_tab[angle_i];
  assign atan_o = ncot_tab[angle_i];

endmodule : trig_table_rom

`default_nettype wire

// File: rtl/trig_lut.sv
//============================================================================
// Module      : trig_lut
// Description : Raycaster trigonometry lookup. Maps a 10-bit binary angle to
//               sin, cos, tan and -1/tan in signed fixed point. The table
//               read is combinational; all four results are registered, so
//               a new angle may be applied every cycle with one cycle of
//               latency and no handshake.
//
// Ports       : clk       - clock
//               rst_n     - asynchronous active-low reset, clears outputs
//               in_angle  - binary angle, 1024 steps per turn
//               out_sin   - sin(theta)
//               out_cos   - cos(theta)
//               out_tan   - tan(theta), saturated, +MAXV at the poles
//               out_atan  - -1/tan(theta), saturated, +MAXV at the poles
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module trig_lut
  import trig_pkg::*;
#(
  parameter int WIDTH_TRIG = WIDTH_TRIG_DEF,
  parameter int FRAC_BITS  = FRAC_BITS_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic        [ANGLE_BITS-1:0] in_angle,
  output logic signed [WIDTH_TRIG-1:0] out_sin,
  output logic signed [WIDTH_TRIG-1:0] out_cos,
  output logic signed [WIDTH_TRIG-1:0] out_tan,
  output logic signed [WIDTH_TRIG-1:0] out_atan
);

  logic signed [WIDTH_TRIG-1:0] sin_d;
  logic signed [WIDTH_TRIG-1:0] cos_d;
  logic signed [WIDTH_TRIG-1:0] tan_d;
  logic signed [WIDTH_TRIG-1:0] atan_d;

  logic signed [WIDTH_TRIG-1:0] sin_q;
  logic signed [WIDTH_TRIG-1:0] cos_q;
  logic signed [WIDTH_TRIG-1:0] tan_q;
  logic signed [WIDTH_TRIG-1:0] atan_q;

  trig_table_rom #(
    .WIDTH_TRIG (WIDTH_TRIG),
    .FRAC_BITS  (FRAC_BITS)
  ) u_rom (
    .angle_i (in_angle),
    .sin_o   (sin_d),
    .cos_o   (cos_d),
    .tan_o   (tan_d),
    .atan_o  (atan_d)
  );

  // Output stage. The clear is asynchronous, so a reset mid-stream zeroes
  // the outputs immediately and drops whatever lookup was in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sin_q  <= '0;
      cos_q  <= '0;
      tan_q  <= '0;
      atan_q <= '0;
    end else begin
      sin_q  <= sin_d;
      cos_q  <= cos_d;
      tan_q  <= tan_d;
      atan_q <= atan_d;
    end
  end

  assign out_sin  = sin_q;
  assign out_cos  = cos_q;
  assign out_tan  = tan_q;
  assign out_atan = atan_q;

endmodule : trig_lut

`default_nettype wire

// File: tb/tb_trig_lut.sv
//============================================================================
// Module      : tb_trig_lut
// Description : Scoreboard bench for trig_lut. Stimulus pushes expected
//               results into a queue as each angle is applied; a monitor
//               pops and compares one cycle later. Reset behaviour is
//               checked directly from the stimulus process.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_trig_lut;

  localparam int  W    = 20;
  localparam int  FB   = 16;
  localparam real MAXV = 524287.0;
  localparam real TPI  = 3.14159265358979323846;

  logic                clk = 1'b0;
  logic                rst_n;
  logic        [9:0]   in_angle;
  logic signed [W-1:0] out_sin;
  logic signed [W-1:0] out_cos;
  logic signed [W-1:0] out_tan;
  logic signed [W-1:0] out_atan;

  always #5 clk = ~clk;

  trig_lut #(
    .WIDTH_TRIG (W),
    .FRAC_BITS  (FB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_angle (in_angle),
    .out_sin  (out_sin),
    .out_cos  (out_cos),
    .out_tan  (out_tan),
    .out_atan (out_atan)
  );

  typedef struct {
    int         angle;
    real        e_sin;
    real        e_cos;
    real        e_tan;
    real        e_atan;
    real        tol_sc;   // tolerance (LSB) for sin/cos
    real        tol_ta;   // tolerance (LSB) for tan/atan
    logic [3:0] mask;     // {atan, tan, cos, sin}
    bit         record;
  } exp_t;

  exp_t sb_q[$];

  int checks   = 0;
  int failures = 0;

  logic stim_valid = 1'b0;
  logic exp_valid  = 1'b0;

  logic signed [W-1:0] obs_sin [0:1023];
  logic signed [W-1:0] obs_cos [0:1023];

  // ------------------------------------------------------------------
  // Helpers
  // ------------------------------------------------------------------
  task automatic cmp(input string name, input int angle,
                     input logic signed [W-1:0] act, input real expv, input real tol);
    real d;
    checks++;
    d = real'(act) - expv;
    if (d < 0.0) d = -d;
    if (d > tol) begin
      failures++;
      $display("FAIL %s angle=%0d actual=%0d required=%0.3f tol=%0.3f",
               name, angle, act, expv, tol);
    end
  endtask

  task automatic check_eq(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, expv);
    end
  endtask

  function automatic exp_t mk(input int a, input real s, input real c,
                              input real t, input real at, input real tsc,
                              input real tta, input logic [3:0] mask, input bit rec);
    exp_t it;
    it.angle  = a;
    it.e_sin  = s;
    it.e_cos  = c;
    it.e_tan  = t;
    it.e_atan = at;
    it.tol_sc = tsc;
    it.tol_ta = tta;
    it.mask   = mask;
    it.record = rec;
    return it;
  endfunction

  // Real-math reference with the same clamp and pole handling; left
  // unrounded so a +/-1 LSB tolerance covers the rounding step.
  function automatic real model_fix(input int kind, input int a);
    real th;
    real v;
    real s;
    th = real'(a) * 2.0 * TPI / 1024.0;
    case (kind)
      0:       v = $sin(th);
      1:       v = $cos(th);
      2: begin
        if (a == 256 || a == 768) return MAXV;
        v = $tan(th);
      end
      default: begin
        if (a == 0 || a == 512) return MAXV;
        v = -1.0 / $tan(th);
      end
    endcase
    s = v * 65536.0;
    if (s > MAXV)  s = MAXV;
    if (s < -MAXV) s = -MAXV;
    return s;
  endfunction

  function automatic exp_t mk_model(input int a);
    return mk(a, model_fix(0, a), model_fix(1, a), model_fix(2, a), model_fix(3, a),
              1.0, 1.0, 4'hF, 1'b1);
  endfunction

  task automatic issue(input exp_t it);
    in_angle   = 10'(it.angle);
    stim_valid = 1'b1;
    sb_q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------------------------
  // Monitor
  // ------------------------------------------------------------------
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_valid <= 1'b0;
    else        exp_valid <= stim_valid;
  end

  always @(negedge clk) begin
    exp_t it;
    if (exp_valid && rst_n) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow actual=output_present required=no_output");
      end else begin
        it = sb_q.pop_front();
        if (it.mask[0]) cmp("sin",  it.angle, out_sin,  it.e_sin,  it.tol_sc);
        if (it.mask[1]) cmp("cos",  it.angle, out_cos,  it.e_cos,  it.tol_sc);
        if (it.mask[2]) cmp("tan",  it.angle, out_tan,  it.e_tan,  it.tol_ta);
        if (it.mask[3]) cmp("atan", it.angle, out_atan, it.e_atan, it.tol_ta);
        if (it.record) begin
          obs_sin[it.angle] = out_sin;
          obs_cos[it.angle] = out_cos;
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  initial begin
    rst_n    = 1'b0;
    in_angle = 10'd128;

    // Reset held with a live angle: outputs stay cleared across edges
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_sin",  out_sin,  0);
    check_eq("rst_cos",  out_cos,  0);
    check_eq("rst_tan",  out_tan,  0);
    check_eq("rst_atan", out_atan, 0);

    // Release between edges; first edge loads angle 128 (45 deg)
    rst_n = 1'b1;
    issue(mk(128, 46341.0, 46341.0, 65536.0, -65536.0, 0.0, 0.0, 4'hF, 1'b0));

    // Cardinal angles back to back
    issue(mk(0,        0.0,  65536.0, 0.0,  MAXV, 0.0, 0.0, 4'hF, 1'b0));
    issue(mk(256,  65536.0,      0.0, MAXV, 0.0,  0.0, 0.0, 4'hF, 1'b0));
    issue(mk(512,      0.0, -65536.0, 0.0,  MAXV, 0.0, 0.0, 4'hF, 1'b0));
    issue(mk(768, -65536.0,      0.0, MAXV, 0.0,  0.0, 0.0, 4'hF, 1'b0));

    // Either side of the 90 degree pole
    issue(mk(255, 65536.0, 0.0,  MAXV, 0.0, 2.0, 0.0, 4'b0101, 1'b0));
    issue(mk(257, 65536.0, 0.0, -MAXV, 0.0, 2.0, 0.0, 4'b0101, 1'b0));

    // Thirds of a turn: 341 -> 119.883 deg, 683 -> 240.117 deg.
    // sin/cos hand-computed at the exact binary angles, tolerance 1e-3.
    issue(mk(341,  0.867046 * 65536.0, -0.498228 * 65536.0, 0.0, 0.0,
             0.001 * 65536.0, 0.0, 4'b0011, 1'b0));
    issue(mk(683, -0.867046 * 65536.0, -0.498228 * 65536.0, 0.0, 0.0,
             0.001 * 65536.0, 0.0, 4'b0011, 1'b0));

    // Full sweep against the real-math model
    for (int a = 0; a < 1024; a++) begin
      issue(mk_model(a));
    end

    // Mid-stream reset
    issue(mk_model(100));
    issue(mk_model(200));
    in_angle   = 10'd300;
    stim_valid = 1'b1;
    sb_q.push_back(mk_model(300));
    #6;                       // past the compare of 200, before the next edge
    rst_n      = 1'b0;
    void'(sb_q.pop_back());   // the in-flight lookup is lost
    stim_valid = 1'b0;
    #1;
    check_eq("midrst_sin",  out_sin,  0);
    check_eq("midrst_cos",  out_cos,  0);
    check_eq("midrst_tan",  out_tan,  0);
    check_eq("midrst_atan", out_atan, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(mk(300, model_fix(0, 300), model_fix(1, 300), model_fix(2, 300),
             model_fix(3, 300), 1.0, 1.0, 4'hF, 1'b0));
    issue(mk(400, model_fix(0, 400), model_fix(1, 400), model_fix(2, 400),
             model_fix(3, 400), 1.0, 1.0, 4'hF, 1'b0));

    // Drain
    stim_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("sb_drain", sb_q.size(), 0);

    // Symmetry over the recorded sweep
    for (int a = 0; a < 1024; a++) begin
      checks++;
      if (obs_sin[a] != -obs_sin[(a + 512) % 1024]) begin
        failures++;
        $display("FAIL sym_sin_neg angle=%0d actual=%0d required=%0d",
                 a, obs_sin[a], -obs_sin[(a + 512) % 1024]);
      end
      checks++;
      if (obs_cos[a] != obs_sin[(a + 256) % 1024]) begin
        failures++;
        $display("FAIL sym_cos_shift angle=%0d actual=%0d required=%0d",
                 a, obs_cos[a], obs_sin[(a + 256) % 1024]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_trig_lut

`default_nettype wire
